// File: rtl/gpio_pattern_sequencer.sv
// Bus-programmed sequencer that plays a timed table of output values onto the
// 8-bit GPIO block by issuing output_en / output_val writes on its master port.
module gpio_pattern_sequencer #(
  parameter int STEPS  = 8,
  parameter int HOLD_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_ss,
  input  logic        s_ttype,
  input  logic [7:0]  s_addr,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  output logic        s_bdone,
  output logic        m_ss,
  output logic        m_ttype,
  output logic [7:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_bdone,
  output logic        busy,
  output logic        irq
);
  localparam int IW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SW = HOLD_W + 8;
  localparam logic [4:0] LEN_MAX = 5'(STEPS);

  typedef enum logic [2:0] {S_IDLE, S_SET_OE, S_SET_VAL, S_HOLD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic [7:0]        m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic              loop_q, done_q;
  logic [7:0]        oe_q;
  logic [4:0]        len_q;
  logic [SW-1:0]     step_q [STEPS];

  logic              wr, start, stop, set_done, step_hit, last_step;
  logic [5:0]        wa;
  logic [IW-1:0]     step_sel, cur_sel, nxt_sel;
  logic [4:0]        len_eff;
  logic [HOLD_W-1:0] cur_hold;
  logic              unused_bits;

  assign wa        = s_addr[7:2];
  assign wr        = s_ss & s_ttype;
  assign start     = wr && (wa == 6'd0) && s_wdata[0] && !s_wdata[1];
  assign stop      = wr && (wa == 6'd0) && s_wdata[1];
  assign step_hit  = (wa >= 6'd4) && (wa < 6'(4 + STEPS));
  assign step_sel  = IW'(wa - 6'd4);
  assign len_eff   = (len_q > LEN_MAX) ? LEN_MAX : len_q;
  assign cur_sel   = idx_q[IW-1:0];
  assign nxt_sel   = IW'(idx_q + 4'd1);
  assign cur_hold  = step_q[cur_sel][SW-1:8];
  assign last_step = ({1'b0, idx_q} == (len_eff - 5'd1));
  assign unused_bits = ^{s_wdata, s_addr};

  assign busy    = (state_q != S_IDLE);
  assign irq     = done_q;
  assign m_ss    = (state_q == S_SET_OE) || (state_q == S_SET_VAL);
  assign m_ttype = 1'b1;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign s_bdone = 1'b1;

  always_comb begin
    s_rdata = '0;
    case (wa)
      6'd0: s_rdata = {29'b0, loop_q, 2'b00};
      6'd1: s_rdata = {24'b0, idx_q, 2'b00, done_q, busy};
      6'd2: s_rdata = {24'b0, oe_q};
      6'd3: s_rdata = {27'b0, len_q};
      default: if (step_hit) s_rdata = 32'(step_q[step_sel]);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    set_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          if (len_eff == 5'd0) begin
            set_done = 1'b1;
          end else begin
            state_d   = S_SET_OE;
            idx_d     = '0;
            m_addr_d  = 8'h08;
            m_wdata_d = {24'b0, oe_q};
          end
        end
      end
      S_SET_OE, S_SET_VAL: begin
        // A STOP during a bus transfer is remembered until the slave completes it.
        if (m_bdone) begin
          if (stop || stop_pend_q) begin
            state_d = S_IDLE;
          end else if (state_q == S_SET_OE) begin
            state_d   = S_SET_VAL;
            m_addr_d  = 8'h0C;
            m_wdata_d = {24'b0, step_q[cur_sel][7:0]};
          end else begin
            state_d = S_HOLD;
            cnt_d   = (cur_hold == '0) ? HOLD_W'(1) : cur_hold;
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_W'(1)) begin
          if (!last_step) begin
            idx_d     = idx_q + 4'd1;
            state_d   = S_SET_VAL;
            m_addr_d  = 8'h0C;
            m_wdata_d = {24'b0, step_q[nxt_sel][7:0]};
          end else if (loop_q) begin
            idx_d     = '0;
            state_d   = S_SET_VAL;
            m_addr_d  = 8'h0C;
            m_wdata_d = {24'b0, step_q[0][7:0]};
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      S_DONE: begin
        set_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      oe_q        <= '0;
      len_q       <= '0;
      for (int i = 0; i < STEPS; i++) step_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if (wr) begin
        case (wa)
          6'd0: loop_q <= s_wdata[2];
          6'd2: if (!busy) oe_q <= s_wdata[7:0];
          6'd3: if (!busy) len_q <= s_wdata[4:0];
          default: if (step_hit) step_q[step_sel] <= s_wdata[SW-1:0];
        endcase
      end
      if (set_done) done_q <= 1'b1;
      else if (wr && (wa == 6'd1) && s_wdata[1]) done_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Bench for gpio_pattern_sequencer: directed and random pattern runs compared
// against a timeline model of the expected GPIO write stream.
module tb_gpio_pattern_sequencer;
  localparam int STEPS = 8;
  localparam int HOLD_W = 16;

  logic        clk, rst, s_ss, s_ttype, s_bdone, m_ss, m_ttype, m_bdone, busy, irq;
  logic [7:0]  s_addr, m_addr;
  logic [31:0] s_wdata, s_rdata, m_wdata;

  gpio_pattern_sequencer #(.STEPS(STEPS), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .s_ss(s_ss), .s_ttype(s_ttype), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone), .m_ss(m_ss),
    .m_ttype(m_ttype), .m_addr(m_addr), .m_wdata(m_wdata), .m_bdone(m_bdone),
    .busy(busy), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  typedef struct {int e; logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t mon[$];
  wr_t expq[$];

  // Completed GPIO transfers, tagged with the edge count of the cycle they occupy.
  always @(negedge clk)
    if (!rst && m_ss && m_bdone) mon.push_back('{ec, m_addr, m_wdata});

  int errors = 0, checks = 0;
  logic [7:0] val [STEPS];
  int hold_a [STEPS];
  logic [7:0] oe;
  int len, done_e, last_idx, wr_e, e0, bd_edge;
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    s_ss = 1'b1; s_ttype = 1'b1; s_addr = a; s_wdata = d;
    @(posedge clk);
    #1;
    s_ss = 1'b0; s_ttype = 1'b0;
    wr_e = ec;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    s_ss = 1'b1; s_ttype = 1'b0; s_addr = a;
    #1 d = s_rdata;
    s_ss = 1'b0;
  endtask

  task automatic wait_ec(input int t);
    int n = 0;
    while (ec < t && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_edge", 32'(ec), 32'(t));
  endtask

  task automatic setup();
    bus_wr(8'h08, {24'b0, oe});
    bus_wr(8'h0C, 32'(len));
    for (int i = 0; i < STEPS; i++)
      bus_wr(8'(16 + 4 * i), {8'b0, 16'(hold_a[i]), val[i]});
  endtask

  // Expected write timeline: OE at the start edge, first value one cycle later,
  // each following value after 1 + max(hold,1) cycles. In loop mode, writes
  // that would begin at or after the stop edge are dropped.
  function automatic void build(input int start_e, input bit lp, input int limit);
    int n, t, k, h;
    n = (len > STEPS) ? STEPS : len;
    expq.delete();
    expq.push_back('{start_e, 8'h08, {24'b0, oe}});
    t = start_e + 1;
    k = 0;
    while (1) begin
      if (lp && t >= limit) break;
      expq.push_back('{t, 8'h0C, {24'b0, val[k]}});
      h = (hold_a[k] == 0) ? 1 : hold_a[k];
      t = t + 1 + h;
      k++;
      if (k == n) begin
        if (!lp) break;
        k = 0;
      end
    end
    done_e = t;
    last_idx = n - 1;
  endfunction

  task automatic cmp_writes(input string tag);
    chk({tag, "_count"}, 32'(mon.size()), 32'(expq.size()));
    for (int i = 0; i < mon.size() && i < expq.size(); i++) begin
      chk({tag, "_edge"}, 32'(mon[i].e), 32'(expq[i].e));
      chk({tag, "_addr"}, {24'b0, mon[i].a}, {24'b0, expq[i].a});
      chk({tag, "_data"}, mon[i].d, expq[i].d);
    end
  endtask

  task automatic play_check(input string tag);
    bus_wr(8'h04, 32'h2);
    mon.delete();
    bus_wr(8'h00, 32'h1);
    e0 = wr_e;
    build(e0, 1'b0, 0);
    wait_ec(done_e);
    chk({tag, "_busy_in_done"}, {31'b0, busy}, 32'd1);
    chk({tag, "_irq_in_done"}, {31'b0, irq}, 32'd0);
    wait_ec(done_e + 1);
    chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    chk({tag, "_irq_end"}, {31'b0, irq}, 32'd1);
    cmp_writes(tag);
    bus_rd(8'h04, rd);
    chk({tag, "_status"}, rd, 32'((last_idx << 4) | 2));
  endtask

  task automatic plan_data();
    oe = 8'hFF; len = 2;
    for (int i = 0; i < STEPS; i++) begin
      val[i] = 8'($urandom);
      hold_a[i] = int'($urandom_range(0, 3));
    end
    val[0] = 8'hA5; hold_a[0] = 3;
    val[1] = 8'h5A; hold_a[1] = 1;
  endtask

  initial begin
    rst = 1'b1; s_ss = 1'b0; s_ttype = 1'b0; s_addr = '0; s_wdata = '0; m_bdone = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_m_ss", {31'b0, m_ss}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_m_addr", {24'b0, m_addr}, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int a = 0; a < 9; a++) begin
      bus_rd(8'(4 * a), rd);
      chk("rst_reg", rd, 32'd0);
    end
    chk("s_bdone", {31'b0, s_bdone}, 32'd1);

    // Directed pattern from the plan.
    plan_data();
    setup();
    play_check("plan");
    bus_wr(8'h04, 32'h2);
    chk("done_clear_irq", {31'b0, irq}, 32'd0);

    // Random tables, including LEN above STEPS and zero holds.
    for (int r = 0; r < 5; r++) begin
      oe = 8'($urandom);
      len = int'($urandom_range(1, STEPS + 3));
      for (int i = 0; i < STEPS; i++) begin
        val[i] = 8'($urandom);
        hold_a[i] = int'($urandom_range(0, 4));
      end
      setup();
      bus_rd(8'h0C, rd);
      chk("len_readback", rd, 32'(len));
      play_check("rand");
    end

    // Zero hold on a single step.
    plan_data();
    len = 1; hold_a[0] = 0;
    setup();
    play_check("hold0");

    // Loop mode then STOP.
    plan_data();
    setup();
    bus_wr(8'h04, 32'h2);
    mon.delete();
    bus_wr(8'h00, 32'h5);
    e0 = wr_e;
    wait_ec(e0 + 10);
    bus_wr(8'h00, 32'h2);
    build(e0, 1'b1, wr_e);
    chk("loop_stop_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("loop_stop_irq", {31'b0, irq}, 32'd0);
    cmp_writes("loop");

    // START while busy and LEN write while busy are ignored.
    plan_data();
    setup();
    mon.delete();
    bus_wr(8'h00, 32'h1);
    e0 = wr_e;
    build(e0, 1'b0, 0);
    bus_wr(8'h0C, 32'h1);
    bus_wr(8'h00, 32'h1);
    wait_ec(done_e + 1);
    cmp_writes("restart");
    bus_rd(8'h0C, rd);
    chk("len_locked", rd, 32'd2);

    // START and STOP together: nothing happens.
    bus_wr(8'h04, 32'h2);
    mon.delete();
    bus_wr(8'h00, 32'h3);
    repeat (5) @(negedge clk);
    chk("startstop_busy", {31'b0, busy}, 32'd0);
    chk("startstop_writes", 32'(mon.size()), 32'd0);

    // Stalled OE write with STOP pending.
    mon.delete();
    m_bdone = 1'b0;
    bus_wr(8'h00, 32'h1);
    chk("stall_m_ss0", {31'b0, m_ss}, 32'd1);
    bus_wr(8'h00, 32'h2);
    chk("stall_m_ss1", {31'b0, m_ss}, 32'd1);
    repeat (2) @(negedge clk);
    chk("stall_m_ss2", {31'b0, m_ss}, 32'd1);
    @(posedge clk);
    #1 m_bdone = 1'b1;
    bd_edge = ec;
    @(posedge clk);
    #1;
    chk("stall_m_ss_end", {31'b0, m_ss}, 32'd0);
    chk("stall_busy_end", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    expq.delete();
    expq.push_back('{bd_edge, 8'h08, 32'h0000_00FF});
    cmp_writes("stall");
    chk("stall_irq", {31'b0, irq}, 32'd0);
    chk("idle_keeps_addr", {24'b0, m_addr}, 32'h08);

    // LEN=0 sets done immediately with no bus activity.
    mon.delete();
    bus_wr(8'h0C, 32'h0);
    bus_wr(8'h00, 32'h1);
    chk("len0_irq", {31'b0, irq}, 32'd1);
    chk("len0_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("len0_writes", 32'(mon.size()), 32'd0);
    bus_wr(8'h04, 32'h2);
    bus_rd(8'h04, rd);
    chk("len0_done_clr", rd & 32'h2, 32'd0);
    chk("len0_irq_clr", {31'b0, irq}, 32'd0);

    // Reset during HOLD.
    plan_data();
    hold_a[0] = 10; hold_a[1] = 10;
    len = 0;
    setup();
    bus_wr(8'h00, 32'h1);
    bus_wr(8'h0C, 32'h2);
    bus_wr(8'h00, 32'h5);
    e0 = wr_e;
    wait_ec(e0 + 4);
    chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_m_ss", {31'b0, m_ss}, 32'd0);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    chk("mid_rst_m_addr", {24'b0, m_addr}, 32'd0);
    mon.delete();
    for (int a = 0; a < 6; a++) begin
      bus_rd(8'(4 * a), rd);
      chk("mid_rst_reg", rd, 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_writes", 32'(mon.size()), 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
